// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit with HI/LO registers
//
// Purpose: shift-add multiplier and restoring divider sharing one 2W-bit
// accumulator, one bit per cycle, with sign fix-up in a final cycle.
// MTHI/MTLO write HI/LO directly in a single cycle.
//
// Ports:
//   clk_i    clock, all state on the rising edge
//   rst_i    synchronous active-high reset
//   start_i  request strobe, accepted only while idle
//   op_i     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   da_i     rs operand (multiplicand / dividend / MTHI-MTLO data)
//   db_i     rt operand (multiplier / divisor)
//   busy_o   high while a multiply or divide is in flight
//   done_o   one-cycle pulse after HI/LO take a mul/div result
//   hi_o     HI register
//   lo_o     LO register

module md_unit #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] da_i,
  input  logic [W-1:0] db_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic           is_div_q, is_div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  // Accumulator layout is shared by both algorithms:
  //   multiply: {partial product high half, remaining multiplier bits}
  //   divide:   {partial remainder, remaining dividend bits / quotient bits}
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_trial;
  logic [2*W-1:0] div_next;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Trial subtract of the divisor from the remainder with the next dividend
  // bit shifted in; bit W set means the trial went negative (restore).
  assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opb_q};
  assign div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                  : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

  logic           signed_op;
  logic [W-1:0]   abs_a, abs_b;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo, rem;

  always_comb begin
    signed_op = (op_i == 3'b000) || (op_i == 3'b010);
    abs_a     = da_i[W-1] ? -da_i : da_i;
    abs_b     = db_i[W-1] ? -db_i : db_i;
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo       = acc_q[W-1:0];
    rem       = acc_q[2*W-1:W];

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          case (op_i)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d   = S_RUN;
              cnt_d     = '0;
              is_div_d  = op_i[1];
              acc_d     = {{W{1'b0}}, (signed_op ? abs_a : da_i)};
              opb_d     = signed_op ? abs_b : db_i;
              neg_res_d = signed_op && (da_i[W-1] ^ db_i[W-1]);
              neg_rem_d = signed_op && da_i[W-1];
              div0_d    = (db_i == '0);
            end
            3'b100:  hi_d = da_i;
            3'b101:  lo_d = da_i;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          // With a zero divisor the remainder path has shifted in |da|,
          // so the sign fix below returns da unchanged; only LO is forced.
          lo_d = div0_q ? {W{1'b1}} : (neg_res_q ? -quo : quo);
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] da, db;
  logic        busy, done;
  logic [31:0] hi, lo;

  int cmps = 0;
  int errs = 0;
  logic [31:0] hi_m, lo_m;

  md_unit #(.W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .da_i(da), .db_i(db), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the defined corner cases.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin sq = sa * sb; r = sq; end
      3'd1: r = ua * ub;
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb; sr = sa % sb;
          r = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else r = {(ua % ub) , 32'b0} | {32'b0, (ua / ub) & 64'hFFFFFFFF};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; da = a; db = b;
    @(negedge clk);
    start = 1'b0; da = $urandom; db = $urandom;
  endtask

  // Called at the negedge n0 edges after the accept edge; returns at the
  // negedge where done is expected.
  task automatic wait_done(input string nm, input bit poke, input int n0);
    int n = n0;
    bit bad_hold = 0;
    bit bad_busy = 0;
    while (done !== 1'b1 && n < 40) begin
      if (hi !== hi_m || lo !== lo_m) bad_hold = 1;
      if (busy !== 1'b1) bad_busy = 1;
      if (poke && (n == 5 || n == 20)) begin
        start = 1'b1; op = 3'($urandom_range(0, 5)); da = $urandom; db = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 64'(n), 64'd33);
    chk({nm, "_hold"}, {63'b0, bad_hold}, 64'd0);
    chk({nm, "_busy_run"}, {63'b0, bad_busy}, 64'd0);
  endtask

  task automatic result(input string nm, input logic [31:0] eh, input logic [31:0] el);
    chk({nm, "_hilo"}, {hi, lo}, {eh, el});
    chk({nm, "_busy_done"}, {63'b0, busy}, 64'd0);
    hi_m = eh; lo_m = el;
  endtask

  task automatic post(input string nm);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit          saw_done;

    vecs[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{3'd3, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF};
    vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
    vecs[6] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{3'd2, 32'h80000001, 32'd0,        32'h80000001, 32'hFFFFFFFF};
    vecs[8] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    vecs[9] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    rst = 1'b1; start = 1'b0; op = 3'd0; da = '0; db = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    hi_m = 0; lo_m = 0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_busy_accept", i), {63'b0, busy}, 64'd1);
      wait_done($sformatf("vec%0d", i), 1'b0, 0);
      result($sformatf("vec%0d", i), vecs[i].eh, vecs[i].el);
      post($sformatf("vec%0d", i));
    end

    // Back-to-back: second start held in the done cycle, pokes during RUN.
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_done("b2b_first", 1'b1, 0);
    result("b2b_first", 32'hFFFFFFFF, 32'hFFFFFFF1);
    start = 1'b1; op = 3'd1; da = 32'd3; db = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_drop", {62'b0, done, busy}, 64'b01);
    wait_done("b2b_second", 1'b1, 0);
    result("b2b_second", 32'd0, 32'd12);
    post("b2b_second");

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    start = 1'b1; op = 3'd4; da = 32'hAAAA5555;
    @(negedge clk);
    chk("mthi", {hi, lo}, {32'hAAAA5555, lo_m});
    op = 3'd5; da = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo", {hi, lo}, {32'hAAAA5555, 32'h12345678});
    chk("mt_no_busy_done", {62'b0, busy, done}, 64'd0);
    hi_m = 32'hAAAA5555; lo_m = 32'h12345678;

    // MTLO while busy is ignored.
    issue(3'd3, 32'd100, 32'd7);
    start = 1'b1; op = 3'd5; da = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_busy_ignored", {32'b0, lo}, {32'b0, lo_m});
    wait_done("mtlo_busy", 1'b0, 1);
    result("mtlo_busy", 32'd2, 32'd14);
    post("mtlo_busy");

    // Randomized ops against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick(); rb = pick();
      issue(ro, ra, rb);
      if (ro <= 3'd3) begin
        e = model(ro, ra, rb);
        wait_done($sformatf("rnd%0d_op%0d", k, ro), 1'($urandom_range(0, 1)), 0);
        result($sformatf("rnd%0d_op%0d", k, ro), e[63:32], e[31:0]);
        post($sformatf("rnd%0d", k));
      end else begin
        if (ro == 3'd4) hi_m = ra;
        if (ro == 3'd5) lo_m = ra;
        chk($sformatf("rnd%0d_op%0d_mt", k, ro), {busy, done, hi, lo}, {2'b00, hi_m, lo_m});
      end
    end

    // Reset in the middle of RUN aborts and clears.
    issue(3'd0, 32'd5, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_run", {busy, done, hi, lo}, 66'd0);
    hi_m = 0; lo_m = 0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) saw_done = 1;
    end
    chk("rst_no_done", {63'b0, saw_done}, 64'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'd4; da = 32'h55;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", {busy, hi, lo}, 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file and consumes its two read-data outputs (`da` = rs, `db` = rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It exposes HI/LO for MFHI/MFLO and raises `busy` so the control path can stall dependent instructions.

## Interface
- `W`, 32, operand width; HI and LO are each `W` bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request strobe, sampled on the rising edge.
- `op` input 3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored (no state change).
- `da` input W: rs operand from the register file read port 1.
- `db` input W: rt operand from the register file read port 2.
- `busy` output 1: high while a multiply or divide is in flight.
- `done` output 1: one-cycle pulse in the cycle HI/LO take a mul/div result.
- `hi` output W: HI register, driven directly from the flop.
- `lo` output W: LO register, driven directly from the flop.

## Operation
- States:
  - IDLE → RUN on an accepted mul/div.
  - RUN → FIX after the W-th iteration.
  - FIX → IDLE.
- Accept rule: `start`=1 with `busy`=0 in IDLE. While `busy`=1, `start` is ignored entirely, including MTHI/MTLO; the control path must stall.
- MTHI/MTLO:
  - On accept, `hi <= da` (MTHI) or `lo <= da` (MTLO).
  - Stays in IDLE, no `busy`, no `done`.
- Operand capture on accept:
  - Latch |da| and |db| for signed ops; raw values for unsigned ops.
  - Latch sign flags: product sign = da[W-1]^db[W-1]; remainder sign = da[W-1].
  - Reset the iteration counter to 0.
- Multiply: shift-add, one multiplier bit per RUN cycle, LSB first, into a 2W-bit accumulator.
- Divide: restoring, one quotient bit per RUN cycle, MSB first. Remainder and quotient are W bits each.
- RUN lasts exactly W cycles; the counter is ceil(log2(W))+1 bits and wraps nowhere.
- FIX applies sign correction (two's-complement negate) and writes HI/LO:
  - MULT/MULTU: {hi,lo} <= 2W-bit product.
  - DIV/DIVU: lo <= quotient, hi <= remainder.
  - Signed divide: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero (db==0), defined behaviour: lo = all ones, hi = da unmodified (signed and unsigned).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- HI/LO are not modified during RUN; old values stay readable until FIX.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Reset in any state aborts the operation and clears HI/LO on the same edge.
- Accept at edge E0:
  - `busy`=1 from just after E0.
  - RUN iterations occur at E1..EW.
  - FIX at EW+1: `hi`/`lo` update, `done`=1 and `busy`=0 for the cycle following EW+1.
- Total latency: W+1 edges from accept to result (33 for W=32).
- `done` is high for exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high (back-to-back).
- MTHI/MTLO latency: result visible one cycle after the accept edge.
- `rst` and `start` asserted together: reset wins.
- `da`/`db` only need to be valid at the accept edge; they are don't-care afterwards.

## Test plan
- Reset: run MULT 5×7, assert `rst` mid-RUN → next cycle `busy`=0, hi=lo=0; no `done` pulse.
- MULT da=0xFFFFFFFD (−3), db=5 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1, one `done` pulse; MULTU on the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIV da=0xFFFFFFF9 (−7), db=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
- Divide by zero DIVU da=0x1234, db=0 → lo=0xFFFFFFFF, hi=0x1234; overflow DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xAAAA5555 then MTLO 0x12345678 on consecutive cycles → hi/lo hold those values one cycle after each accept; MTLO issued while `busy` is ignored, lo unchanged.
- Back-to-back: second MULTU 3×4 with `start` held in the `done` cycle → accepted, result hi=0, lo=12 exactly 33 edges later; `start` pulses during RUN have no effect.
